pending_req_sequencer: RTL and testbench

PENDING_REQ_SEQUENCER -- requirements
Module: pending_req_sequencer

---
 rtl/pending_req_sequencer_pkg.sv | 6 +
 rtl/pending_req_sequencer_lsb_pos_enc4.sv | 20 ++
 rtl/pending_req_sequencer.sv | 90 +++++++++
 tb/tb_pending_req_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pending_req_sequencer_pkg.sv
// Shared sizing for the pending-request sequencer and its priority encoder.
package pending_req_sequencer_pkg;
   localparam int NREQ      = 4;
   localparam int POS_W     = 2;
   localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/pending_req_sequencer_lsb_pos_enc4.sv
// Combinational lowest-set-bit encoder: 4-bit vector to 2-bit index.
// An all-zero input yields index 0; the caller qualifies with |in_vec.
module lsb_pos_enc4
   import pending_req_sequencer_pkg::*;
(
   input  logic [NREQ-1:0]  in_vec,
   output logic [POS_W-1:0] pos
);

   always_comb begin
      pos = '0;
      // Walk from the top so the lowest set bit is the last one written.
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (in_vec[i]) begin
            pos = POS_W'(i);
         end
      end
   end

endmodule

// File: rtl/pending_req_sequencer.sv
// Latches request pulses and issues them lowest-index-first through a one-entry
// staged slot; 2-cycle request-to-grant latency, slot holds while out_ready is low.
module pending_req_sequencer
   import pending_req_sequencer_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic [NREQ-1:0]   req_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [POS_W-1:0]  out_pos,
   output logic [NREQ-1:0]   pending,
   output logic              busy,
   output logic [CNT_W-1:0]  merge_cnt
);

   localparam logic [CNT_W+2:0] CNT_SAT = {3'b000, {CNT_W{1'b1}}};

   logic [NREQ-1:0]  pending_q, pending_d;
   logic             out_valid_q, out_valid_d;
   logic [POS_W-1:0] out_pos_q, out_pos_d;
   logic [CNT_W-1:0] merge_cnt_q, merge_cnt_d;

   logic [POS_W-1:0] sel_pos;
   logic             slot_free;
   logic             load;
   logic [NREQ-1:0]  load_mask;
   logic [NREQ-1:0]  merge_bits;
   logic [2:0]       merge_add;
   logic [CNT_W+2:0] merge_sum;

   lsb_pos_enc4 u_enc (
      .in_vec (pending_q),
      .pos    (sel_pos)
   );

   always_comb begin
      slot_free = !out_valid_q || out_ready;
      load      = slot_free && (pending_q != '0);

      load_mask = '0;
      if (load) begin
         load_mask[sel_pos] = 1'b1;
      end

      // Only bits already pending and not leaving this cycle count as coalesced.
      merge_bits = req_in & pending_q & ~load_mask;
      merge_add  = '0;
      for (int i = 0; i < NREQ; i++) begin
         merge_add = merge_add + {2'b00, merge_bits[i]};
      end
      merge_sum = {3'b000, merge_cnt_q} + {{CNT_W{1'b0}}, merge_add};

      pending_d   = (pending_q & ~load_mask) | req_in;
      out_valid_d = slot_free ? (pending_q != '0) : out_valid_q;
      out_pos_d   = load ? sel_pos : out_pos_q;
      merge_cnt_d = (merge_sum > CNT_SAT) ? {CNT_W{1'b1}} : merge_sum[CNT_W-1:0];

      if (flush) begin
         pending_d   = '0;
         out_valid_d = 1'b0;
         out_pos_d   = out_pos_q;
         merge_cnt_d = merge_cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_pos_q   <= '0;
         merge_cnt_q <= '0;
      end else begin
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_pos_q   <= out_pos_d;
         merge_cnt_q <= merge_cnt_d;
      end
   end

   assign pending   = pending_q;
   assign out_valid = out_valid_q;
   assign out_pos   = out_pos_q;
   assign merge_cnt = merge_cnt_q;
   assign busy      = (|pending_q) || out_valid_q;

endmodule

// File: tb/tb_pending_req_sequencer.sv
// Directed bench: grant indices go through a scoreboard queue checked by a
// handshake monitor; state checks run inline with the stimulus.
module tb_pending_req_sequencer;

   logic       clk = 1'b0;
   logic       resetn;
   logic       flush;
   logic [3:0] req_in;
   logic       out_ready;

   logic       out_valid, busy;
   logic [1:0] out_pos;
   logic [3:0] pending;
   logic [7:0] merge_cnt;

   logic       s_out_valid, s_busy;
   logic [1:0] s_out_pos;
   logic [3:0] s_pending;
   logic [1:0] s_merge_cnt;

   int vecs = 0;
   int miscompares = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   pending_req_sequencer #(.CNT_W(8)) dut (
      .clk(clk), .resetn(resetn), .flush(flush), .req_in(req_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos),
      .pending(pending), .busy(busy), .merge_cnt(merge_cnt)
   );

   pending_req_sequencer #(.CNT_W(2)) dut_sat (
      .clk(clk), .resetn(resetn), .flush(flush), .req_in(req_in),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_pos(s_out_pos),
      .pending(s_pending), .busy(s_busy), .merge_cnt(s_merge_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A grant completes on the edge where out_valid and out_ready are both high,
   // unless flush or reset override it.
   always @(negedge clk) begin
      if (resetn && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            vecs++;
            miscompares++;
            $display("FAIL unexpected_grant: got pos %0d expected none", out_pos);
         end else begin
            chk("grant_pos", int'(out_pos), exp_q.pop_front());
         end
      end
   end

   initial begin
      resetn = 1'b0; flush = 1'b0; req_in = 4'hF; out_ready = 1'b0;
      tick(); tick();
      chk("rst_pending", int'(pending), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_cnt", int'(merge_cnt), 0);
      chk("rst_pos", int'(out_pos), 0);
      chk("rst_busy", int'(busy), 0);
      resetn = 1'b1; req_in = 4'h0;
      tick();
      chk("post_rst_pending", int'(pending), 0);

      // Ordering: 1010 issues index 1 then index 3.
      out_ready = 1'b1; req_in = 4'b1010;
      exp_q.push_back(1); exp_q.push_back(3);
      tick();
      chk("ord_pending", int'(pending), 4'b1010);
      chk("ord_valid0", int'(out_valid), 0);
      req_in = 4'h0;
      tick();
      chk("ord_valid1", int'(out_valid), 1);
      chk("ord_pos1", int'(out_pos), 1);
      tick();
      chk("ord_pos3", int'(out_pos), 3);
      tick();
      chk("ord_valid_end", int'(out_valid), 0);
      chk("ord_busy_end", int'(busy), 0);

      // Backpressure: index 1 held while out_ready is low.
      out_ready = 1'b0; req_in = 4'b0110;
      exp_q.push_back(1); exp_q.push_back(2);
      tick();
      req_in = 4'h0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_pos", int'(out_pos), 1);
         chk("bp_pending", int'(pending), 4'b0100);
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_pos2", int'(out_pos), 2);
      tick();
      chk("bp_valid_end", int'(out_valid), 0);

      // Coalescing: slot holds index 0, index 2 requested three times.
      out_ready = 1'b0; req_in = 4'b0001;
      exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(2);
      tick();
      req_in = 4'h0;
      tick();
      chk("co_pos0", int'(out_pos), 0);
      for (int i = 0; i < 3; i++) begin
         req_in = 4'b0100;
         tick();
      end
      req_in = 4'h0;
      chk("co_cnt", int'(merge_cnt), 2);
      chk("co_pending", int'(pending), 4'b0100);
      out_ready = 1'b1;
      tick();
      chk("co_pos2", int'(out_pos), 2);
      chk("co_pending_empty", int'(pending), 0);
      // Re-request of the staged index is a fresh request, not a merge.
      out_ready = 1'b0; req_in = 4'b0100;
      tick();
      chk("stg_pending", int'(pending), 4'b0100);
      chk("stg_cnt", int'(merge_cnt), 2);
      req_in = 4'h0; out_ready = 1'b1;
      tick();
      chk("stg_pos", int'(out_pos), 2);
      chk("stg_valid", int'(out_valid), 1);
      tick();
      chk("stg_valid_end", int'(out_valid), 0);

      // Saturation: six merges after a fresh reset.
      resetn = 1'b0; out_ready = 1'b0;
      tick();
      resetn = 1'b1;
      tick();
      chk("sat_cnt_rst", int'(merge_cnt), 0);
      req_in = 4'hF;
      tick();
      chk("sat_cnt_first", int'(merge_cnt), 0);
      tick();
      chk("sat_cnt3", int'(merge_cnt), 3);
      chk("sat_pending_reload", int'(pending), 4'hF);
      req_in = 4'b1110;
      tick();
      chk("sat_cnt6", int'(merge_cnt), 6);
      chk("sat_cnt_w2", int'(s_merge_cnt), 3);

      // Flush overrides load, out_ready and req_in.
      chk("fl_pre_valid", int'(out_valid), 1);
      flush = 1'b1; out_ready = 1'b1; req_in = 4'b0001;
      tick();
      flush = 1'b0; req_in = 4'h0;
      chk("fl_pending", int'(pending), 0);
      chk("fl_valid", int'(out_valid), 0);
      chk("fl_busy", int'(busy), 0);
      chk("fl_cnt", int'(merge_cnt), 6);
      tick(); tick();
      chk("fl_idle_valid", int'(out_valid), 0);
      chk("sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
